combo_lock_fsm: RTL



---
 rtl/combo_lock_pkg.sv | 27 ++
 rtl/combo_lock_fsm_if.sv | 37 +++
 rtl/combo_code_store.sv | 70 +++++++
 rtl/combo_lock_fsm.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
// ---------------------------------------------------------------------------
// combo_lock_pkg
// Shared definitions for the combination-lock core: the lock state encoding,
// default sizing parameters and a helper that locates a digit inside the
// packed code word (digit 0 occupies the most significant bits).
// ---------------------------------------------------------------------------
package combo_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        OPEN   = 2'd1,
        NEW    = 2'd2,
        ALARM  = 2'd3
    } lock_state_e;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_DIGIT_W    = 4;
    localparam int DEF_MAX_TRIES  = 3;

    // Bit position of the LSB of digit 'idx' in a code word of num_digits
    // digits. Digit 0 is left-most so the code reads naturally in hex.
    function automatic int digit_lsb(input int idx, input int num_digits,
                                     input int digit_w);
        return (num_digits - 1 - idx) * digit_w;
    endfunction

endpackage

// File: rtl/combo_lock_fsm_if.sv
// ---------------------------------------------------------------------------
// combo_lock_fsm_if
// Groups the key/switch inputs and status outputs of the lock core.
//   digit_in   : current digit from the switches
//   enter      : one-cycle pulse, sample digit_in
//   change     : one-cycle pulse, request a code change
//   lock       : one-cycle pulse, relock or abort a code change
//   Open/Alarm/New : registered status levels
//   digit_cnt  : digits entered in the current sequence
//   tries_left : attempts remaining before alarm
// master = stimulus side (keys/switches), slave = lock core.
// ---------------------------------------------------------------------------
interface combo_lock_fsm_if
    import combo_lock_pkg::*;
#(
    parameter int DIGIT_W = DEF_DIGIT_W
);
    logic [DIGIT_W-1:0] digit_in;
    logic               enter;
    logic               change;
    logic               lock;
    logic               Open;
    logic               Alarm;
    logic               New;
    logic [2:0]         digit_cnt;
    logic [3:0]         tries_left;

    modport master (
        output digit_in, enter, change, lock,
        input  Open, Alarm, New, digit_cnt, tries_left
    );

    modport slave (
        input  digit_in, enter, change, lock,
        output Open, Alarm, New, digit_cnt, tries_left
    );
endinterface

// File: rtl/combo_code_store.sv
// ---------------------------------------------------------------------------
// combo_code_store
// Holds the active code (code_q) and the shadow copy being built during a
// code change (shadow_q).
//   clk, reset  : clock, synchronous active-high reset (reloads DEFAULT_CODE)
//   rd_idx_i    : digit index to read from the active code
//   rd_digit_o  : selected digit of the active code (combinational)
//   wr_en_i     : write wr_digit_i into shadow digit wr_idx_i
//   wr_idx_i    : shadow digit index
//   wr_digit_i  : digit value to write
//   commit_i    : replace the active code with the shadow, including the
//                 digit being written on this same edge
// An aborted change simply never commits; every change session rewrites all
// shadow digits before a commit, so stale shadow content is never exposed.
// ---------------------------------------------------------------------------
module combo_code_store
    import combo_lock_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         rd_idx_i,
    output logic [DIGIT_W-1:0] rd_digit_o,
    input  logic               wr_en_i,
    input  logic [2:0]         wr_idx_i,
    input  logic [DIGIT_W-1:0] wr_digit_i,
    input  logic               commit_i
);
    localparam int CODE_W = NUM_DIGITS * DIGIT_W;

    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] shadow_q;
    logic [CODE_W-1:0] shadow_d;

    always_comb begin
        rd_digit_o = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rd_idx_i == 3'(i)) begin
                rd_digit_o = code_q[digit_lsb(i, NUM_DIGITS, DIGIT_W) +: DIGIT_W];
            end
        end
    end

    // Shadow with the current write merged in, so the final digit can be
    // committed on the same edge it is entered.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_en_i && (wr_idx_i == 3'(i))) begin
                shadow_d[digit_lsb(i, NUM_DIGITS, DIGIT_W) +: DIGIT_W] = wr_digit_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= DEFAULT_CODE;
        end else if (commit_i) begin
            code_q <= shadow_d;
        end
    end

endmodule

// File: rtl/combo_lock_fsm.sv
// ---------------------------------------------------------------------------
// combo_lock_fsm
// Sequential core of the combination lock. Accepts digits one per enter
// pulse, compares them against the stored code, counts consecutive failed
// attempts and supports changing the code while open.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : combo_lock_fsm_if.slave
//           in : digit_in, enter, change, lock
//           out: Open, Alarm, New (registered status, at most one high),
//                digit_cnt (digits entered so far), tries_left
// Status outputs are decoded from the next state and registered so they
// change on the same edge as the state.
// ---------------------------------------------------------------------------
module combo_lock_fsm
    import combo_lock_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int MAX_TRIES  = DEF_MAX_TRIES,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic             clk,
    input  logic             reset,
    combo_lock_fsm_if.slave  bus
);
    localparam logic [2:0] LAST_IDX  = 3'(NUM_DIGITS - 1);
    localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

    lock_state_e        state_q, state_d;
    logic [2:0]         digit_cnt_q, digit_cnt_d;
    logic               mismatch_q, mismatch_d;
    logic [3:0]         tries_q, tries_d;
    logic               open_q, alarm_q, new_q;

    logic [DIGIT_W-1:0] code_digit;
    logic               wr_en;
    logic               commit;
    logic               last_digit;
    logic               seq_miss;

    combo_code_store #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIGIT_W      (DIGIT_W),
        .DEFAULT_CODE (DEFAULT_CODE)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (digit_cnt_q),
        .rd_digit_o (code_digit),
        .wr_en_i    (wr_en),
        .wr_idx_i   (digit_cnt_q),
        .wr_digit_i (bus.digit_in),
        .commit_i   (commit)
    );

    assign last_digit = (digit_cnt_q == LAST_IDX);
    // Mismatch accumulated over the whole sequence including this digit.
    assign seq_miss   = mismatch_q | (bus.digit_in != code_digit);

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        mismatch_d  = mismatch_q;
        tries_d     = tries_q;
        wr_en       = 1'b0;
        commit      = 1'b0;

        unique case (state_q)
            LOCKED: begin
                // enter takes priority over lock; change does nothing here.
                if (bus.enter) begin
                    if (last_digit) begin
                        digit_cnt_d = '0;
                        mismatch_d  = 1'b0;
                        if (!seq_miss) begin
                            state_d = OPEN;
                            tries_d = TRIES_MAX;
                        end else begin
                            tries_d = tries_q - 4'd1;
                            if (tries_q == 4'd1) begin
                                state_d = ALARM;
                            end
                        end
                    end else begin
                        digit_cnt_d = digit_cnt_q + 3'd1;
                        mismatch_d  = seq_miss;
                    end
                end else if (bus.lock) begin
                    digit_cnt_d = '0;
                    mismatch_d  = 1'b0;
                end
            end

            OPEN: begin
                if (bus.change) begin
                    state_d     = NEW;
                    digit_cnt_d = '0;
                end else if (bus.lock) begin
                    state_d     = LOCKED;
                    digit_cnt_d = '0;
                end
            end

            NEW: begin
                // lock aborts even when an enter arrives in the same cycle.
                if (bus.lock) begin
                    state_d     = LOCKED;
                    digit_cnt_d = '0;
                end else if (bus.enter) begin
                    wr_en = 1'b1;
                    if (last_digit) begin
                        commit      = 1'b1;
                        state_d     = LOCKED;
                        digit_cnt_d = '0;
                    end else begin
                        digit_cnt_d = digit_cnt_q + 3'd1;
                    end
                end
            end

            ALARM: begin
                tries_d = '0;
            end

            default: begin
                state_d = LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOCKED;
            digit_cnt_q <= '0;
            mismatch_q  <= 1'b0;
            tries_q     <= TRIES_MAX;
            open_q      <= 1'b0;
            alarm_q     <= 1'b0;
            new_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            mismatch_q  <= mismatch_d;
            tries_q     <= tries_d;
            open_q      <= (state_d == OPEN);
            alarm_q     <= (state_d == ALARM);
            new_q       <= (state_d == NEW);
        end
    end

    assign bus.Open       = open_q;
    assign bus.Alarm      = alarm_q;
    assign bus.New        = new_q;
    assign bus.digit_cnt  = digit_cnt_q;
    assign bus.tries_left = tries_q;

endmodule
